// File: rtl/bias_bank_pkg.sv
// ============================================================================
// Module : bias_bank_pkg
// Brief  : Shared types, default sizes and lane-slice helper for the bias bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bias_bank_pkg;

    localparam int DEF_N_ADDER_TREE = 16;
    localparam int DEF_DATA_W       = 18;
    localparam int DEF_N_GROUPS     = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit offset of a lane inside a packed group row.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bias_bank_mem.sv
// ============================================================================
// Module : bias_bank_mem
// Brief  : N_GROUPS x N_ADDER_TREE bias storage, per-lane write, async group read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bias_bank_mem
    import bias_bank_pkg::*;
#(
    parameter int N_ADDER_TREE = DEF_N_ADDER_TREE,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int N_GROUPS     = DEF_N_GROUPS,
    parameter int GRP_W        = $clog2(N_GROUPS),
    parameter int LANE_W       = $clog2(N_ADDER_TREE)
) (
    input  logic                           clk,
    input  logic                           i_wr_en,
    input  logic [GRP_W-1:0]               i_wr_group,
    input  logic [LANE_W-1:0]              i_wr_lane,
    input  logic [DATA_W-1:0]              i_wr_data,
    input  logic [GRP_W-1:0]               i_rd_group,
    output logic [N_ADDER_TREE*DATA_W-1:0] o_rd_data
);

    logic w_in_range;
    logic w_we;

    if (N_GROUPS == (2 ** GRP_W)) begin : g_full_range
        assign w_in_range = 1'b1;
    end else begin : g_part_range
        assign w_in_range = ({1'b0, i_wr_group} < (GRP_W + 1)'(N_GROUPS));
    end

    assign w_we = i_wr_en && w_in_range;

    // One narrow array per lane keeps each lane's write enable independent.
    for (genvar l = 0; l < N_ADDER_TREE; l++) begin : g_lane
        logic [DATA_W-1:0] r_bank [N_GROUPS];

        always_ff @(posedge clk) begin
            if (w_we && (i_wr_lane == LANE_W'(l))) begin
                r_bank[i_wr_group] <= i_wr_data;
            end
        end

        assign o_rd_data[lane_lsb(l, DATA_W) +: DATA_W] = r_bank[i_rd_group];
    end

endmodule

`default_nettype wire

// File: rtl/bias_stream_bank.sv
// ============================================================================
// Module : bias_stream_bank
// Brief  : Loadable bias store streaming a wrapped group range under valid/ready.
//          Optional BIAS_BANK_WRITE_PROTECT_EN rejects writes while streaming.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bias_stream_bank
    import bias_bank_pkg::*;
#(
    parameter int N_ADDER_TREE = DEF_N_ADDER_TREE,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int N_GROUPS     = DEF_N_GROUPS,
    parameter int GRP_W        = $clog2(N_GROUPS),
    parameter int LANE_W       = $clog2(N_ADDER_TREE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [GRP_W-1:0]               wr_group,
    input  logic [LANE_W-1:0]              wr_lane,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           start,
    input  logic [GRP_W-1:0]               first_group,
    input  logic [GRP_W-1:0]               last_group,
    output logic                           q_valid,
    input  logic                           q_ready,
    output logic [N_ADDER_TREE*DATA_W-1:0] q,
    output logic [GRP_W-1:0]               q_group,
    output logic                           busy,
    output logic                           done,
    output logic                           wr_err
);

    localparam int                Q_W        = N_ADDER_TREE * DATA_W;
    localparam int                CNT_W      = GRP_W + 1;
    localparam logic [GRP_W-1:0]  C_LAST_GRP = GRP_W'(N_GROUPS - 1);
    localparam logic [CNT_W-1:0]  C_N_GROUPS = CNT_W'(N_GROUPS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GRP_W-1:0]   r_grp;
    logic [CNT_W-1:0]   r_remain;
    logic               r_q_valid;
    logic [Q_W-1:0]     r_q;
    logic [GRP_W-1:0]   r_q_group;
    logic               r_done;

    logic               w_busy;
    logic               w_start;
    logic               w_accept;
    logic               w_load;
    logic               w_last_acc;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_remain_src;
    logic [GRP_W-1:0]   w_rd_group;
    logic [GRP_W-1:0]   w_grp_inc;
    logic [Q_W-1:0]     w_rd_data;
    logic               w_wr_en;

    // Inclusive range length, wrapping past the top group back to 0.
    always_comb begin
        if (last_group >= first_group) begin
            w_count = {1'b0, last_group} - {1'b0, first_group} + CNT_W'(1);
        end else begin
            w_count = C_N_GROUPS - {1'b0, first_group} + {1'b0, last_group} + CNT_W'(1);
        end
    end

    assign w_start      = (r_state == ST_IDLE) && start;
    assign w_accept     = r_q_valid && q_ready;
    assign w_last_acc   = (r_state == ST_RUN) && w_accept && (r_remain == '0);
    assign w_load       = w_start ||
                          ((r_state == ST_RUN) && (!r_q_valid || q_ready) && (r_remain != '0));
    // The first beat is fetched straight from first_group so it appears one edge after start.
    assign w_rd_group   = (r_state == ST_IDLE) ? first_group : r_grp;
    assign w_grp_inc    = (w_rd_group == C_LAST_GRP) ? '0 : w_rd_group + 1'b1;
    assign w_remain_src = w_start ? w_count : r_remain;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)      w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_acc) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state == ST_RUN) begin
            w_busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_valid <= 1'b0;
            r_q       <= '0;
            r_q_group <= '0;
            r_done    <= 1'b0;
            r_grp     <= '0;
            r_remain  <= '0;
        end else begin
            r_done <= w_last_acc;
            if (w_load) begin
                r_q       <= w_rd_data;
                r_q_group <= w_rd_group;
                r_q_valid <= 1'b1;
                r_grp     <= w_grp_inc;
                r_remain  <= w_remain_src - CNT_W'(1);
            end else if (w_accept) begin
                r_q_valid <= 1'b0;
            end
        end
    end

`ifdef BIAS_BANK_WRITE_PROTECT_EN
    logic r_wr_err;

    assign w_wr_en = wr_en && !w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && w_busy;
        end
    end

    assign wr_err = r_wr_err;
`else
    assign w_wr_en = wr_en;
    assign wr_err  = 1'b0;
`endif

    bias_bank_mem #(
        .N_ADDER_TREE (N_ADDER_TREE),
        .DATA_W       (DATA_W),
        .N_GROUPS     (N_GROUPS),
        .GRP_W        (GRP_W),
        .LANE_W       (LANE_W)
    ) u_mem (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_group (wr_group),
        .i_wr_lane  (wr_lane),
        .i_wr_data  (wr_data),
        .i_rd_group (w_rd_group),
        .o_rd_data  (w_rd_data)
    );

    assign q_valid = r_q_valid;
    assign q       = r_q;
    assign q_group = r_q_group;
    assign busy    = w_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bias_stream_bank.sv
// ============================================================================
// Module : tb_bias_stream_bank
// Brief  : Directed self-checking bench for bias_stream_bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bias_stream_bank;

    localparam int NT = 16;
    localparam int DW = 18;
    localparam int NG = 64;
    localparam int QW = NT * DW;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [5:0]    wr_group;
    logic [3:0]    wr_lane;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [5:0]    first_group;
    logic [5:0]    last_group;
    logic          q_valid;
    logic          q_ready;
    logic [QW-1:0] q;
    logic [5:0]    q_group;
    logic          busy;
    logic          done;
    logic          wr_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [NG][NT];

    bias_stream_bank dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_group    (wr_group),
        .wr_lane     (wr_lane),
        .wr_data     (wr_data),
        .start       (start),
        .first_group (first_group),
        .last_group  (last_group),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q           (q),
        .q_group     (q_group),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [QW-1:0] model_row(input int g);
        logic [QW-1:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[i*DW +: DW] = mdl[g][i];
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
        total++; if (q !== '0)         begin bad++; $display("FAIL reset_q got=%h exp=0", q); end
        total++; if (q_group !== 6'd0) begin bad++; $display("FAIL reset_q_group got=%0d exp=0", q_group); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (wr_err !== 1'b0)  begin bad++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
        rst = 1'b0;
        tick;
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL post_reset_q_valid got=%b exp=0", q_valid); end
    endtask

    task automatic load_all;
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < NT; i++) begin
                wr_en    = 1'b1;
                wr_group = 6'(g);
                wr_lane  = 4'(i);
                wr_data  = DW'(g * 16 + i);
                mdl[g][i] = DW'(g * 16 + i);
                tick;
            end
        end
        wr_en = 1'b0;
    endtask

    // Full-rate stream of an inclusive, possibly wrapping, group range.
    task automatic test_stream(input int first, input int last, input string name);
        int n;
        int g;
        logic [5:0] eg;
        n = ((last - first + NG) % NG) + 1;
        q_ready     = 1'b1;
        first_group = 6'(first);
        last_group  = 6'(last);
        start       = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            g  = (first + k) % NG;
            eg = 6'(g);
            total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL %s q_valid beat=%0d got=%b exp=1", name, k, q_valid); end
            total++; if (q_group !== eg)   begin bad++; $display("FAIL %s q_group beat=%0d got=%0d exp=%0d", name, k, q_group, eg); end
            total++; if (q !== model_row(g)) begin bad++; $display("FAIL %s q beat=%0d got=%h exp=%h", name, k, q, model_row(g)); end
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s busy_done beat=%0d got=%b%b exp=10", name, k, busy, done); end
            tick;
        end
        total++; if (done !== 1'b1)    begin bad++; $display("FAIL %s done got=%b exp=1", name, done); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL %s end_busy got=%b exp=0", name, busy); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL %s end_q_valid got=%b exp=0", name, q_valid); end
        total++; if (q !== model_row(last)) begin bad++; $display("FAIL %s q_kept got=%h exp=%h", name, q, model_row(last)); end
        tick;
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL %s done_pulse got=%b exp=0", name, done); end
    endtask

    task automatic test_stall;
        q_ready     = 1'b0;
        first_group = 6'd5;
        last_group  = 6'd5;
        start       = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (q_valid !== 1'b1 || q_group !== 6'd5) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%0d exp=1/5", k, q_valid, q_group); end
            total++; if (q !== model_row(5)) begin bad++; $display("FAIL stall_q cyc=%0d got=%h exp=%h", k, q, model_row(5)); end
            total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_busy cyc=%0d got=%b%b exp=10", k, busy, done); end
            tick;
        end
        q_ready = 1'b1;
        tick;
        total++; if (done !== 1'b1 || q_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_end got=done%b v%b b%b exp=done1 v0 b0", done, q_valid, busy); end
        tick;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_read_first;
        logic [QW-1:0] old_row;
        logic [DW-1:0] lane7;
        old_row     = model_row(2);
        q_ready     = 1'b1;
        first_group = 6'd2;
        last_group  = 6'd2;
        start       = 1'b1;
        wr_en       = 1'b1;
        wr_group    = 6'd2;
        wr_lane     = 4'd7;
        wr_data     = 18'h3FFFB;
        tick;
        start = 1'b0;
        wr_en = 1'b0;
        mdl[2][7] = 18'h3FFFB;
        lane7 = q[7*DW +: DW];
        total++; if (lane7 !== 18'd39) begin bad++; $display("FAIL rf_old_lane7 got=%h exp=%h", lane7, 18'd39); end
        total++; if (q !== old_row) begin bad++; $display("FAIL rf_old_row got=%h exp=%h", q, old_row); end
        tick;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rf_done got=%b exp=1", done); end
        tick;
        test_stream(2, 2, "rf_rerun");
        lane7 = q[7*DW +: DW];
        total++; if (lane7 !== 18'h3FFFB) begin bad++; $display("FAIL rf_new_lane7 got=%h exp=3fffb", lane7); end
    endtask

    task automatic test_reset_mid;
        q_ready     = 1'b1;
        first_group = 6'd10;
        last_group  = 6'd20;
        start       = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        total++; if (q_group !== 6'd12) begin bad++; $display("FAIL rm_progress got=%0d exp=12", q_group); end
        rst = 1'b1;
        tick;
        total++; if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rm_abort got=v%b b%b d%b exp=v0 b0 d0", q_valid, busy, done); end
        rst = 1'b0;
        tick;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_no_done got=d%b b%b exp=d0 b0", done, busy); end
        test_stream(10, 11, "rm_rerun");
    endtask

    task automatic test_protect;
        q_ready     = 1'b0;
        first_group = 6'd30;
        last_group  = 6'd33;
        start       = 1'b1;
        tick;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wp_busy got=%b exp=1", busy); end
        wr_en    = 1'b1;
        wr_group = 6'd40;
        wr_lane  = 4'd3;
        wr_data  = 18'h12345;
        tick;
        wr_en = 1'b0;
`ifdef BIAS_BANK_WRITE_PROTECT_EN
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wp_err got=%b exp=1", wr_err); end
`else
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wp_err got=%b exp=0", wr_err); end
        mdl[40][3] = 18'h12345;
`endif
        tick;
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wp_err_pulse got=%b exp=0", wr_err); end
        q_ready = 1'b1;
        repeat (4) tick;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL wp_done got=%b exp=1", done); end
        tick;
        test_stream(40, 40, "wp_check");
    endtask

    initial begin
        rst         = 1'b0;
        wr_en       = 1'b0;
        wr_group    = '0;
        wr_lane     = '0;
        wr_data     = '0;
        start       = 1'b0;
        first_group = '0;
        last_group  = '0;
        q_ready     = 1'b0;

        test_reset;
        load_all;
        test_stream(0, 3, "basic");
        test_stream(62, 1, "wrap");
        test_stall;
        test_read_first;
        test_reset_mid;
        test_protect;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
